// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and sizing helpers for the multiplexed BCD display.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int MIN_DIGITS = 1;
  localparam int MAX_DIGITS = 8;

  localparam logic [7:0] SEG_DASH    = 8'hBF;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] ANODES_OFF  = 8'hFF;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h98;
      default: return SEG_BLANK;
    endcase
  endfunction

  // ceil(w * log10(2)) + 1, in fixed point so it stays a constant function
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one input bit per cycle,
// followed by a single done cycle in which the result is valid.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int BCD_D = bcd_digits(BIN_W)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [4*BCD_D-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

  conv_state_t        state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BIN_W-1:0]   bin_sr, bin_n;
  logic [4*BCD_D-1:0] bcd_sr, bcd_n, adj;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= CONV_IDLE;
      cnt    <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bin_sr <= bin_n;
      bcd_sr <= bcd_n;
    end
  end

  // Any BCD digit of 5 or more would overflow on the next doubling.
  always_comb begin
    adj = bcd_sr;
    for (int d = 0; d < BCD_D; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bin_n   = bin_sr;
    bcd_n   = bcd_sr;
    case (state)
      CONV_IDLE: begin
        if (start) begin
          bin_n   = bin;
          bcd_n   = '0;
          cnt_n   = '0;
          state_n = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        {bcd_n, bin_n} = {adj, bin_sr} << 1;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST_BIT)
          state_n = CONV_DONE;
      end
      CONV_DONE: state_n = CONV_IDLE;
      default:   state_n = CONV_IDLE;
    endcase
  end

  assign busy = (state != CONV_IDLE);
  assign done = (state == CONV_DONE);
  assign bcd  = bcd_sr;

endmodule

// File: rtl/display_scan_bcd.sv
// Multiplexed 7-segment driver: converts a binary value to BCD, then scans the
// digits with leading-zero blanking, overflow dashes and registered outputs.
module display_scan_bcd
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int BIN_W    = 8,
  parameter int REFRESH  = 100_000,
  parameter int BLANK_LZ = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [BIN_W-1:0] Sal,
  input  logic             Load,
  input  logic             Enable,
  output logic             Busy,
  output logic             Overflow,
  output logic [7:0]       Displays,
  output logic [7:0]       Segmentos
);

  localparam int BCD_D  = bcd_digits(BIN_W);
  localparam int ALL_D  = (DIGITS > BCD_D) ? DIGITS : BCD_D;
  localparam int EXT_W  = 4 * ALL_D;
  localparam int RCNT_W = $clog2(REFRESH);
  localparam logic [2:0]        LAST_IDX = 3'(DIGITS - 1);
  localparam logic [RCNT_W-1:0] LAST_CNT = RCNT_W'(REFRESH - 1);

  logic                  conv_done;
  logic [4*BCD_D-1:0]    bcd;
  logic [EXT_W-1:0]      bcd_ext;
  logic [4*DIGITS-1:0]   digits, digits_n;
  logic                  ovf_n;
  logic [RCNT_W-1:0]     rcnt;
  logic [2:0]            idx;
  logic [MAX_DIGITS-1:0] lz;
  logic                  lz_acc;
  logic [3:0]            cur;
  logic [7:0]            seg_sel;

  bin2bcd_seq #(
    .BIN_W (BIN_W),
    .BCD_D (BCD_D)
  ) u_conv (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (Load),
    .bin   (Sal),
    .busy  (Busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Zero-extend so small BIN_W with many digits still indexes cleanly.
  assign bcd_ext = EXT_W'(bcd);

  always_comb begin
    ovf_n = 1'b0;
    for (int i = DIGITS; i < ALL_D; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0)
        ovf_n = 1'b1;
    end
    digits_n = bcd_ext[4*DIGITS-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      digits   <= '0;
      Overflow <= 1'b0;
    end else if (conv_done) begin
      digits   <= digits_n;
      Overflow <= ovf_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rcnt <= '0;
      idx  <= 3'd0;
    end else if (rcnt == LAST_CNT) begin
      rcnt <= '0;
      idx  <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // lz[i] is set when digit i and everything above it are zero.
  always_comb begin
    lz     = '1;
    lz_acc = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_acc = lz_acc & (digits[4*i +: 4] == 4'd0);
      lz[i]  = lz_acc;
    end
  end

  assign cur = digits[{idx, 2'b00} +: 4];

  always_comb begin
    if (Overflow)
      seg_sel = SEG_DASH;
    else if ((BLANK_LZ != 0) && (idx != 3'd0) && lz[idx])
      seg_sel = SEG_BLANK;
    else
      seg_sel = seg_code(cur);
  end

  always_ff @(posedge Clk) begin
    if (Rst || !Enable) begin
      Displays  <= ANODES_OFF;
      Segmentos <= SEG_BLANK;
    end else begin
      Displays  <= ~(8'd1 << idx);
      Segmentos <= seg_sel;
    end
  end

endmodule
